fir_mac_sched: RTL and testbench

- Single-multiplier FIR tap scheduler on the read side of the dual-clock sample FIFO, running entirely in the rd_clk domain.
- Pops one sample per output and keeps a TAPS-deep circular delay line.
- Time-multiplexes one multiplier/accumulator across all taps, then presents the result on a valid/ready output.
- Coefficients are loaded through a simple register-write port.

---
 rtl/fir_mac_sched.sv | 168 ++++++++++++++++
 tb/tb_fir_mac_sched.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_sched.sv
// fir_mac_sched: single-multiplier FIR tap scheduler on the FIFO read side.
// Pops one sample per output into a TAPS-deep circular delay line, then
// walks all taps through one shared multiply/accumulate before presenting
// the result on a valid/ready port.
// Optional build macro FIR_FLUSH_EN adds a 'flush' input that clears the
// delay line and head pointer while IDLE.
module fir_mac_sched #(
  parameter int DWIDTH = 16,
  parameter int CWIDTH = 16,
  parameter int TWIDTH = 3,
  parameter int OWIDTH = DWIDTH + CWIDTH + TWIDTH
) (
  input  logic              rd_clk,
  input  logic              areset_n,
  input  logic [DWIDTH-1:0] fifo_q,
  input  logic              fifo_empty,
  output logic              fifo_read,
  input  logic              coef_we,
  input  logic [TWIDTH-1:0] coef_addr,
  input  logic [CWIDTH-1:0] coef_data,
`ifdef FIR_FLUSH_EN
  input  logic              flush,
`endif
  output logic [OWIDTH-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy
);

  localparam int TAPS   = 1 << TWIDTH;
  localparam int PWIDTH = DWIDTH + CWIDTH;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_MAC   = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  localparam logic [TWIDTH-1:0] T_ONE  = {{(TWIDTH-1){1'b0}}, 1'b1};
  localparam logic [TWIDTH-1:0] T_LAST = {TWIDTH{1'b1}};

  logic [2:0]               state_q, state_d;
  logic [TWIDTH-1:0]        head_q, head_d;
  logic [TWIDTH-1:0]        k_q, k_d;
  logic signed [OWIDTH-1:0] acc_q, acc_d;
  logic [OWIDTH-1:0]        dout_q, dout_d;
  logic signed [DWIDTH-1:0] x_q [TAPS];
  logic signed [DWIDTH-1:0] x_d [TAPS];
  logic signed [CWIDTH-1:0] c_q [TAPS];
  logic signed [CWIDTH-1:0] c_d [TAPS];

  logic [TWIDTH-1:0]        head_inc_s;
  logic [TWIDTH-1:0]        tap_idx_s;
  logic signed [PWIDTH-1:0] prod_s;
  logic signed [OWIDTH-1:0] prod_ext_s;
  logic signed [OWIDTH-1:0] sum_s;

  // Shared datapath: tap k pairs the sample k outputs old with c[k].
  always_comb begin
    head_inc_s = head_q + T_ONE;
    tap_idx_s  = head_q - k_q;
    prod_s     = x_q[tap_idx_s] * c_q[k_q];
    prod_ext_s = {{(OWIDTH-PWIDTH){prod_s[PWIDTH-1]}}, prod_s};
    sum_s      = acc_q + prod_ext_s;
  end

  // Next-state logic for the scheduler, delay line and coefficient bank.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    k_d     = k_q;
    acc_d   = acc_q;
    dout_d  = dout_q;
    x_d     = x_q;
    c_d     = c_q;
    case (state_q)
      S_IDLE: begin
        // Coefficients may only change between passes.
        if (coef_we) begin
          c_d[coef_addr] = $signed(coef_data);
        end else begin
          c_d = c_q;
        end
`ifdef FIR_FLUSH_EN
        // A flush wins over starting a new fetch in the same cycle.
        if (flush) begin
          for (int i = 0; i < TAPS; i++) begin
            x_d[i] = {DWIDTH{1'b0}};
          end
          head_d  = {TWIDTH{1'b0}};
          state_d = S_IDLE;
        end else if (!fifo_empty) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
`else
        if (!fifo_empty) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
`endif
      end
      S_FETCH: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        // FIFO data is valid now, one cycle after the pop strobe.
        head_d            = head_inc_s;
        x_d[head_inc_s]   = $signed(fifo_q);
        acc_d             = {OWIDTH{1'b0}};
        k_d               = {TWIDTH{1'b0}};
        state_d           = S_MAC;
      end
      S_MAC: begin
        acc_d = sum_s;
        k_d   = k_q + T_ONE;
        if (k_q == T_LAST) begin
          dout_d  = sum_s;
          state_d = S_OUT;
        end else begin
          state_d = S_MAC;
        end
      end
      S_OUT: begin
        if (dout_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_OUT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, pointer, accumulator and storage registers.
  always_ff @(posedge rd_clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= S_IDLE;
      head_q  <= {TWIDTH{1'b0}};
      k_q     <= {TWIDTH{1'b0}};
      acc_q   <= {OWIDTH{1'b0}};
      dout_q  <= {OWIDTH{1'b0}};
      for (int i = 0; i < TAPS; i++) begin
        x_q[i] <= {DWIDTH{1'b0}};
        c_q[i] <= {CWIDTH{1'b0}};
      end
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      dout_q  <= dout_d;
      x_q     <= x_d;
      c_q     <= c_d;
    end
  end

  // Output decodes come straight from the state register.
  assign fifo_read  = (state_q == S_FETCH);
  assign dout_valid = (state_q == S_OUT);
  assign busy       = (state_q != S_IDLE);
  assign dout       = dout_q;

endmodule

// File: tb/tb_fir_mac_sched.sv
// Scoreboard bench for fir_mac_sched: stimulus pushes expected outputs into
// a queue, a monitor pops and compares on every dout handshake.
module tb_fir_mac_sched;
  localparam int DW = 16;
  localparam int CW = 16;
  localparam int TW = 3;
  localparam int OW = DW + CW + TW;

  logic          rd_clk = 1'b0;
  logic          areset_n;
  logic [DW-1:0] fifo_q = '0;
  logic          fifo_empty;
  logic          fifo_read;
  logic          coef_we;
  logic [TW-1:0] coef_addr;
  logic [CW-1:0] coef_data;
  logic          flush;
  logic [OW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          busy;

  // FIFO model
  logic [DW-1:0] mem [0:255];
  int            wr_idx = 0;
  int            rd_idx = 0;
  int            cyc = 0;

  logic signed [OW-1:0] exp_q [$];

  int tot_s = 0, bad_s = 0, tot_m = 0, bad_m = 0;
  int hs_cyc = 0;
  int last_read = -100;

  always #5 rd_clk = ~rd_clk;

  assign fifo_empty = (wr_idx == rd_idx);

  fir_mac_sched dut (
    .rd_clk     (rd_clk),
    .areset_n   (areset_n),
    .fifo_q     (fifo_q),
    .fifo_empty (fifo_empty),
    .fifo_read  (fifo_read),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
`ifdef FIR_FLUSH_EN
    .flush      (flush),
`endif
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy)
  );

  // Cycle counter and FIFO read port (data valid the cycle after the pop).
  always @(posedge rd_clk) begin
    cyc <= cyc + 1;
    if (fifo_read) begin
      fifo_q <= mem[rd_idx & 255];
      rd_idx <= rd_idx + 1;
    end
  end

  // Monitor: protocol checks and scoreboard compares.
  initial begin
    logic prev_valid;
    logic signed [OW-1:0] e;
    prev_valid = 1'b0;
    forever begin
      @(negedge rd_clk);
      if (!areset_n) begin
        prev_valid = 1'b0;
      end else begin
        if (fifo_read) begin
          tot_m++;
          if (fifo_empty || dout_valid) begin
            bad_m++;
            $display("FAIL read_guard: fifo_read=1 with empty=%0b valid=%0b (required both 0)", fifo_empty, dout_valid);
          end
          last_read = cyc;
        end
        if (dout_valid && !prev_valid) begin
          tot_m++;
          if (cyc - last_read != 10) begin
            bad_m++;
            $display("FAIL latency: got %0d cycles, required 10", cyc - last_read);
          end
        end
        if (dout_valid && dout_ready) begin
          tot_m++;
          if (exp_q.size() == 0) begin
            bad_m++;
            $display("FAIL unexpected_out: dout=%0d with empty scoreboard", $signed(dout));
          end else begin
            e = exp_q.pop_front();
            if ($signed(dout) != e) begin
              bad_m++;
              $display("FAIL dout: got %0d, required %0d", $signed(dout), e);
            end
          end
          hs_cyc = cyc;
        end
        prev_valid = dout_valid;
      end
    end
  end

  task automatic chk(input string nm, input longint act, input longint req);
    tot_s++;
    if (act != req) begin
      bad_s++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] s, input longint ev);
    exp_q.push_back(ev[OW-1:0]);
    mem[wr_idx & 255] = s;
    wr_idx = wr_idx + 1;
  endtask

  task automatic wcoef(input int a, input logic [CW-1:0] d);
    step();
    coef_we   = 1'b1;
    coef_addr = a[TW-1:0];
    coef_data = d;
    step();
    coef_we   = 1'b0;
  endtask

  task automatic wait_read(output int c);
    bit found;
    found = 1'b0;
    c = 0;
    for (int n = 0; n < 300 && !found; n++) begin
      @(negedge rd_clk);
      if (fifo_read) begin
        found = 1'b1;
        c = cyc;
      end
    end
    if (!found) chk("read_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 3000 && !done; n++) begin
      @(negedge rd_clk);
      if (exp_q.size() == 0 && !busy && fifo_empty) done = 1'b1;
    end
    if (!done) chk("drain_timeout", exp_q.size(), 0);
  endtask

  // Directed stimulus.
  initial begin
    int rc, prev;
    logic seen_read, seen_valid, seen_busy, seen_dout, drop, moved;
    logic [OW-1:0] hold;

    areset_n = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    flush = 1'b0; dout_ready = 1'b1;
    repeat (3) step();
    areset_n = 1'b1;

    // Reset state with FIFO empty for 20 cycles.
    seen_read = 0; seen_valid = 0; seen_busy = 0; seen_dout = 0;
    repeat (20) begin
      @(negedge rd_clk);
      seen_read  |= fifo_read;
      seen_valid |= dout_valid;
      seen_busy  |= busy;
      seen_dout  |= (dout != '0);
    end
    chk("rst_fifo_read", seen_read, 0);
    chk("rst_dout_valid", seen_valid, 0);
    chk("rst_busy", seen_busy, 0);
    chk("rst_dout_nonzero", seen_dout, 0);

    // Impulse response with c[k]=k+1, back-to-back samples.
    for (int k = 0; k < 8; k++) wcoef(k, CW'(k + 1));
    step();
    for (int i = 0; i < 9; i++) push((i == 0) ? 16'd1 : 16'd0, (i < 8) ? i + 1 : 0);
    prev = 0;
    for (int i = 0; i < 9; i++) begin
      wait_read(rc);
      if (i > 0) chk("read_spacing", rc - prev, 12);
      prev = rc;
    end
    wait_drain();

    // Signed extremes: c=-1, samples -32768.
    for (int k = 0; k < 8; k++) wcoef(k, 16'hFFFF);
    step();
    for (int n = 1; n <= 8; n++) push(16'h8000, n * 32768);
    wait_drain();
    // Zeros shift the -32768s out again.
    step();
    for (int n = 1; n <= 8; n++) push(16'd0, (8 - n) * 32768);
    wait_drain();

    // Coefficient write during MAC is dropped.
    for (int k = 0; k < 8; k++) wcoef(k, CW'(k + 1));
    step();
    push(16'd1, 1);
    wait_read(rc);
    step(); step();
    coef_we = 1'b1; coef_addr = 3'd0; coef_data = 16'd5;
    step();
    coef_we = 1'b0;
    wait_drain();
    chk("busy_after_gate", busy, 0);
    // Same write in IDLE takes effect.
    wcoef(0, 16'd5);
    step();
    for (int n = 1; n <= 7; n++) push(16'd0, n + 1);
    push(16'd0, 0);
    push(16'd1, 5);
    wait_drain();

    // Backpressure: history 1,0,... with c={5,2,3,...,8}.
    step();
    dout_ready = 1'b0;
    push(16'd2, 12);
    push(16'd3, 22);
    begin
      bit got;
      got = 1'b0;
      for (int n = 0; n < 100 && !got; n++) begin
        @(negedge rd_clk);
        if (dout_valid) got = 1'b1;
      end
      chk("bp_valid_seen", got, 1);
    end
    hold = dout; drop = 0; moved = 0; seen_read = 0;
    repeat (10) begin
      @(negedge rd_clk);
      drop      |= !dout_valid;
      moved     |= (dout != hold);
      seen_read |= fifo_read;
    end
    chk("bp_valid_held", drop, 0);
    chk("bp_dout_stable", moved, 0);
    chk("bp_no_read", seen_read, 0);
    chk("bp_fifo_nonempty", fifo_empty, 0);
    chk("bp_held_value", $signed(hold), 12);
    step();
    dout_ready = 1'b1;
    wait_read(rc);
    chk("bp_read_gap", rc - hs_cyc, 2);
    wait_drain();

`ifdef FIR_FLUSH_EN
    // Fill with 100s under unity coefficients (history was 3,2,1,0...).
    for (int k = 0; k < 8; k++) wcoef(k, 16'd1);
    step();
    push(16'd100, 106); push(16'd100, 206); push(16'd100, 306); push(16'd100, 406);
    push(16'd100, 506); push(16'd100, 605); push(16'd100, 703); push(16'd100, 800);
    wait_drain();
    // Flush in IDLE with a sample waiting: flush first, then the 0 sees a clean line.
    step();
    flush = 1'b1;
    push(16'd0, 0);
    step();
    flush = 1'b0;
    wait_drain();
    // Flush during MAC is ignored.
    step();
    push(16'd5, 5);
    wait_read(rc);
    step(); step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    wait_drain();
    step();
    push(16'd0, 5);
    wait_drain();
`endif

    repeat (5) step();
    $display("test done: total=%0d bad=%0d", tot_s + tot_m, bad_s + bad_m);
    $finish;
  end

  // Global watchdog.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

endmodule
